uart_tx: RTL and testbench

//   Byte-wide UART transmitter. It serialises bytes produced by the x3q16 core
//   (data_out path) onto the tx pin, which drives uo_out[4].
//   It is the outbound counterpart of uart_rx and uses the same speed/set_speed

---
 rtl/uart_tx_if.sv | 19 +
 rtl/uart_tx.sv | 101 ++++++++++
 tb/tb_uart_tx.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// uart_tx_if: core-side handshake, divisor control and serial status of the UART transmitter
interface uart_tx_if;
   logic [12:0] speed;
   logic        set_speed;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        tx;
   logic        tx_busy;
   logic        tx_done;
   modport master (
      output speed, set_speed, tx_data, tx_valid,
      input  tx_ready, tx, tx_busy, tx_done
   );
   modport slave (
      input  speed, set_speed, tx_data, tx_valid,
      output tx_ready, tx, tx_busy, tx_done
   );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with one-byte holding register; UART_TX_PARITY_EN adds a parity bit (8P1)
module uart_tx #(
   parameter logic [12:0] DEFAULT_SPEED = 13'h1869
`ifdef UART_TX_PARITY_EN
   , parameter bit PARITY_ODD = 1'b0
`endif
) (
   input logic      clk,
   input logic      reset,
   uart_tx_if.slave bus
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t      state;
   logic [12:0] div, shadow, cnt;
   logic [7:0]  hold, shifter;
   logic [2:0]  bit_cnt;
   logic        hold_full, tx_q, done_q, last, load;
`ifdef UART_TX_PARITY_EN
   logic        par;
`endif
   assign last         = cnt == shadow;
   assign load         = hold_full && (state == IDLE || (state == STOP && last));
   assign bus.tx_ready = !hold_full;
   assign bus.tx       = tx_q;
   assign bus.tx_busy  = state != IDLE;
   assign bus.tx_done  = done_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         div       <= DEFAULT_SPEED;
         shadow    <= 13'd0;
         cnt       <= 13'd0;
         hold      <= 8'd0;
         shifter   <= 8'd0;
         bit_cnt   <= 3'd0;
         hold_full <= 1'b0;
         tx_q      <= 1'b1;
         done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par       <= 1'b0;
`endif
      end else begin
         if (bus.set_speed) div <= bus.speed;
         if (load) hold_full <= 1'b0;
         else if (bus.tx_valid && !hold_full) begin
            hold      <= bus.tx_data;
            hold_full <= 1'b1;
         end
         done_q <= 1'b0;
         cnt    <= last ? 13'd0 : cnt + 13'd1;
         case (state)
            IDLE: begin
               tx_q <= 1'b1;
               cnt  <= 13'd0;
            end
            START: if (last) begin
               state   <= DATA;
               tx_q    <= shifter[0];
               bit_cnt <= 3'd0;
            end
            DATA: if (last) begin
               if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state  <= PARITY;
                  tx_q   <= par;
`else
                  state  <= STOP;
                  tx_q   <= 1'b1;
                  done_q <= shadow == 13'd0;
`endif
               end else begin
                  bit_cnt <= bit_cnt + 3'd1;
                  shifter <= shifter >> 1;
                  tx_q    <= shifter[1];
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (last) begin
               state  <= STOP;
               tx_q   <= 1'b1;
               done_q <= shadow == 13'd0;
            end
`endif
            // done is registered, so it is raised one cycle ahead of the final stop cycle
            STOP: if (last) state <= IDLE;
                  else done_q <= cnt + 13'd1 == shadow;
            default: state <= IDLE;
         endcase
         if (load) begin
            state   <= START;
            shifter <= hold;
            shadow  <= div;
            tx_q    <= 1'b0;
            cnt     <= 13'd0;
`ifdef UART_TX_PARITY_EN
            par     <= ^hold ^ PARITY_ODD;
`endif
         end
      end
   end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed stimulus with a bit-position frame model checked every cycle
module tb_uart_tx;
   localparam logic [12:0] DEF = 13'h1869;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int failures = 0;
   uart_tx_if bus();
   uart_tx dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   bit          m_valid = 1'b0, m_in = 1'b0, m_pend = 1'b0, m_acc;
   int          m_pos = 0, m_p = 1;
   logic [12:0] m_div = DEF;
   logic [7:0]  m_byte = 8'd0, m_pend_byte = 8'd0;

   task automatic chk1(input string n, input logic a, input logic e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%b required=%b at %0t", n, a, e, $time);
      end
   endtask

   task automatic chkn(input string n, input int a, input int e);
      checks++;
      if (a != e) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", n, a, e);
      end
   endtask

   function automatic logic bitval(input logic [7:0] b, input int k);
      logic [7:0] s;
      s = b >> (k - 1);
      if (k == 0) return 1'b0;
      if (k <= 8) return s[0];
`ifdef UART_TX_PARITY_EN
      if (k == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   // Model: a frame is NB bit slots of m_p cycles each, starting one cycle after the byte is held
   initial forever begin
      @(posedge clk);
      if (reset) begin
         m_valid = 1'b1;
         m_in    = 1'b0;
         m_pend  = 1'b0;
         m_div   = DEF;
         m_pos   = 0;
      end else if (m_valid) begin
         m_acc = bus.tx_valid && !m_pend;
         if (m_in) begin
            m_pos++;
            if (m_pos == NB * m_p) m_in = 1'b0;
         end
         if (!m_in && m_pend) begin
            m_in   = 1'b1;
            m_pos  = 0;
            m_p    = {19'd0, m_div} + 1;
            m_byte = m_pend_byte;
            m_pend = 1'b0;
         end
         if (m_acc) begin
            m_pend      = 1'b1;
            m_pend_byte = bus.tx_data;
         end
         if (bus.set_speed) m_div = bus.speed;
      end
   end

   initial forever begin
      @(negedge clk);
      if (m_valid) begin
         chk1("tx", bus.tx, m_in ? bitval(m_byte, m_pos / m_p) : 1'b1);
         chk1("ready", bus.tx_ready, !m_pend);
         chk1("busy", bus.tx_busy, m_in);
         chk1("done", bus.tx_done, m_in && m_pos == NB * m_p - 1);
      end
   end

   task automatic send(input logic [7:0] b);
      int n = 0;
      @(posedge clk); #1;
      while (!bus.tx_ready && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      chk1("send_ready", bus.tx_ready, 1'b1);
      bus.tx_data  = b;
      bus.tx_valid = 1'b1;
      @(posedge clk); #1;
      bus.tx_valid = 1'b0;
   endtask

   task automatic set_div(input logic [12:0] s);
      @(posedge clk); #1;
      bus.speed     = s;
      bus.set_speed = 1'b1;
      @(posedge clk); #1;
      bus.set_speed = 1'b0;
   endtask

   task automatic frame(input int p, input int maxc, output int len, output int lows,
                        output int dones, output int rlow, output logic [10:0] bits);
      int n = 0;
      int k;
      len = 0; lows = 0; dones = 0; rlow = 0; bits = '1;
      while (!bus.tx_busy && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk1("frame_start", bus.tx_busy, 1'b1);
      while (bus.tx_busy && len < maxc) begin
         k = len / p;
         if (len % p == p / 2 && k < 11) bits[k[3:0]] = bus.tx;
         lows  += bus.tx ? 0 : 1;
         dones += bus.tx_done ? 1 : 0;
         rlow  += bus.tx_ready ? 0 : 1;
         len++;
         @(negedge clk);
      end
   endtask

   initial begin
      int len, lows, dones, rl, bad, d, l;
      logic [10:0] bits, exp_bits;
      bus.speed = 13'd0; bus.set_speed = 1'b0; bus.tx_data = 8'd0; bus.tx_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.tx !== 1'b1 || bus.tx_ready !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) bad++;
      end
      chkn("idle_outputs", bad, 0);

      send(8'h00);
      frame(6250, 100000, len, lows, dones, rl, bits);
      chkn("def_len", len, NB * 6250);
      chkn("def_low", lows, 56250 + (NB - 10) * 6250);
      chkn("def_high", len - lows, 6250);
      chkn("def_done", dones, 1);

      set_div(13'd3);
      send(8'hA5);
      frame(4, 500, len, lows, dones, rl, bits);
`ifdef UART_TX_PARITY_EN
      exp_bits = {1'b1, 1'b0, 8'hA5, 1'b0};
      chkn("a5_len", len, 44);
`else
      exp_bits = {1'b1, 1'b1, 8'hA5, 1'b0};
      chkn("a5_len", len, 40);
`endif
      chkn("a5_bits", {21'd0, bits}, {21'd0, exp_bits});
      chkn("a5_done", dones, 1);

      fork
         frame(4, 500, len, lows, dones, rl, bits);
         begin
            send(8'h55);
            send(8'h0F);
         end
      join
      chkn("b2b_len", len, 2 * NB * 4);
      chkn("b2b_done", dones, 2);
      chkn("b2b_ready_low", rl, NB * 4 - 1);
      chk1("b2b_ready_after", bus.tx_ready, 1'b1);

      fork
         frame(4, 500, len, lows, dones, rl, bits);
         begin
            send(8'hFF);
            repeat (18) @(posedge clk);
            #1 bus.speed = 13'd1; bus.set_speed = 1'b1;
            @(posedge clk); #1 bus.set_speed = 1'b0;
         end
      join
      chkn("spd_cur_len", len, NB * 4);
      chkn("spd_cur_low", lows, 4 + (NB - 10) * 4);
      send(8'h03);
      frame(2, 500, len, lows, dones, rl, bits);
      chkn("spd_next_len", len, NB * 2);
      chkn("spd_next_low", lows, 14 + (NB - 10) * 2);

      set_div(13'd3);
      send(8'hC3);
      send(8'h3C);
      repeat (10) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      chk1("rst_tx", bus.tx, 1'b1);
      chk1("rst_ready", bus.tx_ready, 1'b1);
      chk1("rst_busy", bus.tx_busy, 1'b0);
      d = 0; l = 0;
      repeat (100) begin
         @(negedge clk);
         d += bus.tx_done ? 1 : 0;
         l += bus.tx ? 0 : 1;
      end
      chkn("rst_no_done", d, 0);
      chkn("rst_no_frame", l, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1500000;
      failures++;
      $display("FAIL watchdog time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
